dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (CPU port) and a secondary DMA/test-loader port (valid/ready handshake).
- CPU has priority by default; a starvation counter forces a DMA grant and stalls the pipeline for one cycle.
- Sits between the MEM stage and the data memory and drives its address, write-data and write-enable pins.
- Memory read is combinational, so CPU accesses complete in the granted cycle. DMA read data is returned registered, one cycle later.

Parameters:
- AW, 32, address width; word index into memory.
- DW, 32, data width.
- DEPTH, 100, number of valid memory words; addresses >= DEPTH are out of range.
- MAX_WAIT, 4, consecutive denied DMA cycles before a forced DMA grant (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- cpu_req  in  1  MEM stage requests memory this cycle.
- cpu_we  in  1  CPU write (store) when 1, read (load) when 0.
- cpu_addr  in  AW  CPU word address.
- cpu_wdata  in  DW  CPU store data.
- cpu_rdata  out  DW  CPU load data, combinational.
- cpu_stall  out  1  CPU access not performed this cycle; pipeline must hold.
- dma_valid  in  1  DMA request pending.
- dma_we  in  1  DMA write when 1.
- dma_addr  in  AW  DMA word address.
- dma_wdata  in  DW  DMA write data.
- dma_ready  out  1  DMA request accepted this cycle (transfer when dma_valid && dma_ready).
- dma_rvalid  out  1  registered pulse one cycle after an accepted DMA read.
- dma_rdata  out  DW  registered DMA read data.
- addr_err  out  1  sticky flag: some access targeted an address >= DEPTH.
- mem_a  out  AW  memory address.
- mem_wd  out  DW  memory write data.
- mem_we  out  1  memory write enable.
- mem_rd  in  DW  memory read data, combinational.

Behaviour:
- State machine with two states.
  - ST_CPU (reset state).
    - cpu_req=1: grant CPU.
    - cpu_req=0 and dma_valid=1: grant DMA.
  - ST_FORCE: grant DMA unconditionally. cpu_stall = cpu_req.
- Starvation counter wait_cnt (4 bits, reset 0).
  - Increments when dma_valid=1 and DMA is not granted.
  - Clears on a DMA grant or when dma_valid=0.
  - When wait_cnt reaches MAX_WAIT-1 and DMA is denied again, next state = ST_FORCE.
  - ST_FORCE lasts exactly one cycle, then returns to ST_CPU.
  - If dma_valid drops while in ST_FORCE: no transfer, no stall; return to ST_CPU.
- Muxing: mem_a, mem_wd and mem_we follow the granted port. With no grant, mem_we=0 and mem_a=0.
- cpu_stall=0 whenever the CPU is granted or cpu_req=0. The CPU is never stalled in ST_CPU.
- dma_ready=1 exactly in cycles where DMA is granted and dma_valid=1.
- Accepted DMA read: dma_rdata <= mem_rd and dma_rvalid <= 1 at the next edge. Otherwise dma_rvalid <= 0 and dma_rdata holds its value.
- Out-of-range address (addr >= DEPTH) on the granted port:
  - mem_we forced 0; the read returns 0 (cpu_rdata or dma_rdata).
  - Handshake and stall behave normally.
  - addr_err <= 1, sticky until reset.
- Writes and reads are issued the same way for both ports; a write takes effect at the edge ending the grant cycle.
- Reset, asynchronous and taking effect immediately, including mid-transfer:
  - state=ST_CPU, wait_cnt=0, dma_rvalid=0, dma_rdata=0, addr_err=0.
  - Combinational outputs follow from this reset state.
  - A pending dma_rvalid is dropped.

Optional Feature:
- DMEM_ARB_STATS_EN defined:
  - Adds outputs stall_cnt[15:0] (cycles with cpu_stall=1) and dma_cnt[15:0] (accepted DMA transfers).
  - Both saturate at 0xFFFF and reset to 0.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum (ST_CPU, ST_FORCE);
  - the grant encoding (GNT_NONE, GNT_CPU, GNT_DMA);
  - the default DEPTH and MAX_WAIT constants.
- One natural sub-module, dmem_arb_starve: the wait counter plus force-decision logic. It outputs force_next.

Test Plan:
- After reset: cpu_req=1 write addr 5 data 0xABCD, dma_valid=0 -> mem_we=1, mem_a=5, cpu_stall=0; a later CPU read of addr 5 returns 0xABCD the same cycle.
- cpu_req=0, DMA write addr 7 data 0x1234 -> dma_ready=1 that cycle. Then DMA read addr 7 -> dma_rvalid=1 one cycle later with dma_rdata=0x1234.
- cpu_req=1 and dma_valid=1 held continuously, MAX_WAIT=4:
  - cycles 0-3: CPU granted, dma_ready=0.
  - cycle 4: dma_ready=1, cpu_stall=1.
  - cycle 5: CPU granted again.
- In ST_FORCE with dma_valid dropped -> no DMA transfer, cpu_stall=0, state returns to ST_CPU.
- CPU write to addr 100 (DEPTH=100) -> mem_we=0, addr_err=1 from the next cycle and held. A CPU read of addr 150 returns 0.
- Assert rst during a DMA read grant cycle -> dma_rvalid stays 0, wait_cnt=0, addr_err=0; normal operation resumes after rst falls.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        ST_CPU   = 1'b0,
        ST_FORCE = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_DMA  = 2'd2
    } gnt_t;

    localparam int DEF_DEPTH    = 100;
    localparam int DEF_MAX_WAIT = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, DMA and memory-pin bundle; slave is the arbiter's view, master the environment's.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          dma_valid;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_ready;
    logic          dma_rvalid;
    logic [DW-1:0] dma_rdata;
    logic          addr_err;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic          mem_we;
    logic [DW-1:0] mem_rd;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_valid, dma_we, dma_addr, dma_wdata,
        output dma_ready, dma_rvalid, dma_rdata, addr_err,
        output mem_a, mem_wd, mem_we,
        input  mem_rd
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_valid, dma_we, dma_addr, dma_wdata,
        input  dma_ready, dma_rvalid, dma_rdata, addr_err,
        input  mem_a, mem_wd, mem_we,
        output mem_rd
    );
endinterface

// File: rtl/dmem_arb_starve.sv
// DMA starvation counter; raises force_next on the MAX_WAIT-th consecutive denial.
module dmem_arb_starve #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic dma_valid,
    input  logic dma_gnt,
    output logic force_next
);
    logic [3:0] wait_cnt_r;
    logic       denied_s;

    // Denial detect and force decision
    always_comb begin
        denied_s   = dma_valid && !dma_gnt;
        force_next = denied_s && (wait_cnt_r == 4'(MAX_WAIT - 1));
    end

    // Consecutive-denial counter, cleared by a grant or an idle DMA port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= 4'd0;
        end else if (!denied_s) begin
            wait_cnt_r <= 4'd0;
        end else if (wait_cnt_r != 4'hF) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU priority with forced DMA grant on starvation.
// Optional statistics counters are enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]    stall_cnt,
    output logic [15:0]    dma_cnt
`endif
);
    state_t        state_r;
    state_t        state_s;
    gnt_t          gnt_s;
    logic          force_next_s;
    logic          dma_gnt_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;
    logic          sel_we_s;
    logic          oor_s;
    logic [DW-1:0] rd_masked_s;
    logic          dma_rvalid_r;
    logic [DW-1:0] dma_rdata_r;
    logic          addr_err_r;

    assign dma_gnt_s = (gnt_s == GNT_DMA);

    dmem_arb_starve #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk        (clk),
        .rst        (rst),
        .dma_valid  (bus.dma_valid),
        .dma_gnt    (dma_gnt_s),
        .force_next (force_next_s)
    );

    // Grant selection and next state
    always_comb begin
        gnt_s   = GNT_NONE;
        state_s = ST_CPU;
        case (state_r)
            ST_CPU: begin
                if (bus.cpu_req) begin
                    gnt_s = GNT_CPU;
                end else if (bus.dma_valid) begin
                    gnt_s = GNT_DMA;
                end else begin
                    gnt_s = GNT_NONE;
                end
            end
            ST_FORCE: begin
                // A withdrawn DMA request hands the slot back to the CPU
                if (bus.dma_valid) begin
                    gnt_s = GNT_DMA;
                end else if (bus.cpu_req) begin
                    gnt_s = GNT_CPU;
                end else begin
                    gnt_s = GNT_NONE;
                end
            end
            default: gnt_s = GNT_NONE;
        endcase
        if (force_next_s) begin
            state_s = ST_FORCE;
        end else begin
            state_s = ST_CPU;
        end
    end

    // Memory-pin mux and range check for the granted port
    always_comb begin
        sel_addr_s  = {AW{1'b0}};
        sel_wdata_s = {DW{1'b0}};
        sel_we_s    = 1'b0;
        case (gnt_s)
            GNT_CPU: begin
                sel_addr_s  = bus.cpu_addr;
                sel_wdata_s = bus.cpu_wdata;
                sel_we_s    = bus.cpu_we;
            end
            GNT_DMA: begin
                sel_addr_s  = bus.dma_addr;
                sel_wdata_s = bus.dma_wdata;
                sel_we_s    = bus.dma_we;
            end
            default: begin
                sel_addr_s  = {AW{1'b0}};
                sel_wdata_s = {DW{1'b0}};
                sel_we_s    = 1'b0;
            end
        endcase
        oor_s       = (gnt_s != GNT_NONE) && (sel_addr_s >= AW'(DEPTH));
        rd_masked_s = oor_s ? {DW{1'b0}} : bus.mem_rd;
    end

    assign bus.mem_a      = sel_addr_s;
    assign bus.mem_wd     = sel_wdata_s;
    assign bus.mem_we     = sel_we_s && !oor_s;
    assign bus.cpu_rdata  = (gnt_s == GNT_CPU) ? rd_masked_s : {DW{1'b0}};
    assign bus.cpu_stall  = bus.cpu_req && (gnt_s != GNT_CPU);
    assign bus.dma_ready  = dma_gnt_s;
    assign bus.dma_rvalid = dma_rvalid_r;
    assign bus.dma_rdata  = dma_rdata_r;
    assign bus.addr_err   = addr_err_r;

    // State, registered DMA read return and sticky range error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_CPU;
            dma_rvalid_r <= 1'b0;
            dma_rdata_r  <= {DW{1'b0}};
            addr_err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            if (dma_gnt_s && !bus.dma_we) begin
                dma_rvalid_r <= 1'b1;
                dma_rdata_r  <= rd_masked_s;
            end else begin
                dma_rvalid_r <= 1'b0;
            end
            if (oor_s) begin
                addr_err_r <= 1'b1;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stall_cnt_r;
    logic [15:0] dma_cnt_r;

    // Saturating stall and DMA-transfer counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 16'd0;
            dma_cnt_r   <= 16'd0;
        end else begin
            if (bus.cpu_stall) begin
                stall_cnt_r <= sat_inc16(stall_cnt_r);
            end
            if (dma_gnt_s) begin
                dma_cnt_r <= sat_inc16(dma_cnt_r);
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign dma_cnt   = dma_cnt_r;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed steps push expectations, a negedge monitor checks.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] dma_cnt;
`endif

    dmem_arbiter #(.AW(32), .DW(32), .DEPTH(100), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .dma_cnt   (dma_cnt)
`endif
    );

    // Memory model: combinational read, write on the rising edge
    logic [31:0] mem [0:255];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'hDEAD_0000 | 32'(i);
    end

    always @(posedge clk) begin
        if (bus.mem_we === 1'b1 && bus.mem_a < 32'd256) mem[bus.mem_a[7:0]] <= bus.mem_wd;
    end

    assign bus.mem_rd = (bus.mem_a < 32'd256) ? mem[bus.mem_a[7:0]] : 32'h0;

    typedef struct {
        int          id;
        logic        we;
        logic [31:0] a;
        logic        stall;
        logic        ready;
        logic [31:0] rdata;
        logic        rvalid;
        logic        err;
    } exp_t;

    exp_t        cq[$];
    logic [31:0] rq[$];
    int          errors  = 0;
    int          checks  = 0;
    int          step_id = 0;

    localparam logic [31:0] M5  = 32'hDEAD_0005;
    localparam logic [31:0] M10 = 32'hDEAD_000A;
    localparam logic [31:0] M20 = 32'hDEAD_0014;

    task automatic chk(input int id, input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL step%0d %s got=%h want=%h", id, nm, got, want);
        end
    endtask

    // Monitor: per-cycle outputs from the expectation queue, DMA read data on dma_rvalid
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] w;
        if (cq.size() > 0) begin
            e = cq.pop_front();
            chk(e.id, "mem_we",     {31'b0, bus.mem_we},     {31'b0, e.we});
            chk(e.id, "mem_a",      bus.mem_a,               e.a);
            chk(e.id, "cpu_stall",  {31'b0, bus.cpu_stall},  {31'b0, e.stall});
            chk(e.id, "dma_ready",  {31'b0, bus.dma_ready},  {31'b0, e.ready});
            chk(e.id, "cpu_rdata",  bus.cpu_rdata,           e.rdata);
            chk(e.id, "dma_rvalid", {31'b0, bus.dma_rvalid}, {31'b0, e.rvalid});
            chk(e.id, "addr_err",   {31'b0, bus.addr_err},   {31'b0, e.err});
        end
        if (bus.dma_rvalid === 1'b1) begin
            if (rq.size() > 0) begin
                w = rq.pop_front();
                chk(step_id, "dma_rdata", bus.dma_rdata, w);
            end else begin
                checks++;
                errors++;
                $display("FAIL step%0d dma_rvalid unexpected data=%h want no pulse", step_id, bus.dma_rdata);
            end
        end
    end

    task automatic step(
        input logic creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwd,
        input logic dv, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd,
        input logic ewe, input logic [31:0] ea, input logic estall, input logic erdy,
        input logic [31:0] erd, input logic erv, input logic eerr,
        input logic push_rd, input logic [31:0] erd_dma);
        exp_t e;
        @(posedge clk);
        #1;
        bus.cpu_req   = creq;
        bus.cpu_we    = cwe;
        bus.cpu_addr  = caddr;
        bus.cpu_wdata = cwd;
        bus.dma_valid = dv;
        bus.dma_we    = dwe;
        bus.dma_addr  = daddr;
        bus.dma_wdata = dwd;
        step_id++;
        e.id = step_id; e.we = ewe; e.a = ea; e.stall = estall; e.ready = erdy;
        e.rdata = erd; e.rvalid = erv; e.err = eerr;
        cq.push_back(e);
        if (push_rd) rq.push_back(erd_dma);
    endtask

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'd0; bus.cpu_wdata = 32'd0;
        bus.dma_valid = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = 32'd0; bus.dma_wdata = 32'd0;

        // Reset state
        step(1'b0,1'b0,32'd0,32'd0, 1'b0,1'b0,32'd0,32'd0, 1'b0,32'd0,1'b0,1'b0,32'd0,1'b0,1'b0, 1'b0,32'd0);
        @(negedge clk); #1 rst = 1'b0;

        // CPU write then read back
        step(1'b1,1'b1,32'd5,32'hABCD, 1'b0,1'b0,32'd0,32'd0, 1'b1,32'd5,1'b0,1'b0,M5,1'b0,1'b0, 1'b0,32'd0);
        step(1'b1,1'b0,32'd5,32'd0, 1'b0,1'b0,32'd0,32'd0, 1'b0,32'd5,1'b0,1'b0,32'hABCD,1'b0,1'b0, 1'b0,32'd0);
        // DMA write then registered read
        step(1'b0,1'b0,32'd0,32'd0, 1'b1,1'b1,32'd7,32'h1234, 1'b1,32'd7,1'b0,1'b1,32'd0,1'b0,1'b0, 1'b0,32'd0);
        step(1'b0,1'b0,32'd0,32'd0, 1'b1,1'b0,32'd7,32'd0, 1'b0,32'd7,1'b0,1'b1,32'd0,1'b0,1'b0, 1'b1,32'h1234);
        step(1'b0,1'b0,32'd0,32'd0, 1'b0,1'b0,32'd0,32'd0, 1'b0,32'd0,1'b0,1'b0,32'd0,1'b1,1'b0, 1'b0,32'd0);

        // Contention: four CPU grants, forced DMA, then CPU again
        for (int i = 0; i < 4; i++)
            step(1'b1,1'b0,32'd10,32'd0, 1'b1,1'b0,32'd20,32'd0, 1'b0,32'd10,1'b0,1'b0,M10,1'b0,1'b0, 1'b0,32'd0);
        step(1'b1,1'b0,32'd10,32'd0, 1'b1,1'b0,32'd20,32'd0, 1'b0,32'd20,1'b1,1'b1,32'd0,1'b0,1'b0, 1'b1,M20);
        step(1'b1,1'b0,32'd10,32'd0, 1'b1,1'b0,32'd20,32'd0, 1'b0,32'd10,1'b0,1'b0,M10,1'b1,1'b0, 1'b0,32'd0);
        for (int i = 0; i < 3; i++)
            step(1'b1,1'b0,32'd10,32'd0, 1'b1,1'b0,32'd20,32'd0, 1'b0,32'd10,1'b0,1'b0,M10,1'b0,1'b0, 1'b0,32'd0);
        // Forced cycle with DMA withdrawn: CPU served, no stall
        step(1'b1,1'b0,32'd10,32'd0, 1'b0,1'b0,32'd20,32'd0, 1'b0,32'd10,1'b0,1'b0,M10,1'b0,1'b0, 1'b0,32'd0);
        // Back in CPU-priority state
        step(1'b1,1'b0,32'd10,32'd0, 1'b1,1'b0,32'd20,32'd0, 1'b0,32'd10,1'b0,1'b0,M10,1'b0,1'b0, 1'b0,32'd0);

        // Out-of-range write and read
        step(1'b1,1'b1,32'd100,32'h5555, 1'b0,1'b0,32'd0,32'd0, 1'b0,32'd100,1'b0,1'b0,32'd0,1'b0,1'b0, 1'b0,32'd0);
        step(1'b1,1'b0,32'd150,32'd0, 1'b0,1'b0,32'd0,32'd0, 1'b0,32'd150,1'b0,1'b0,32'd0,1'b0,1'b1, 1'b0,32'd0);
        step(1'b0,1'b0,32'd0,32'd0, 1'b0,1'b0,32'd0,32'd0, 1'b0,32'd0,1'b0,1'b0,32'd0,1'b0,1'b1, 1'b0,32'd0);

        // Reset asserted during a forced DMA read grant
        for (int i = 0; i < 4; i++)
            step(1'b1,1'b0,32'd10,32'd0, 1'b1,1'b0,32'd20,32'd0, 1'b0,32'd10,1'b0,1'b0,M10,1'b0,1'b1, 1'b0,32'd0);
        step(1'b1,1'b0,32'd10,32'd0, 1'b1,1'b0,32'd20,32'd0, 1'b0,32'd20,1'b1,1'b1,32'd0,1'b0,1'b1, 1'b0,32'd0);
        #6 rst = 1'b1;
        step(1'b0,1'b0,32'd0,32'd0, 1'b0,1'b0,32'd0,32'd0, 1'b0,32'd0,1'b0,1'b0,32'd0,1'b0,1'b0, 1'b0,32'd0);
        @(negedge clk); #1 rst = 1'b0;

        // Normal operation resumes; starvation count restarts from zero
        for (int i = 0; i < 4; i++)
            step(1'b1,1'b0,32'd10,32'd0, 1'b1,1'b0,32'd20,32'd0, 1'b0,32'd10,1'b0,1'b0,M10,1'b0,1'b0, 1'b0,32'd0);
        step(1'b1,1'b0,32'd10,32'd0, 1'b1,1'b0,32'd20,32'd0, 1'b0,32'd20,1'b1,1'b1,32'd0,1'b0,1'b0, 1'b1,M20);
        step(1'b0,1'b0,32'd0,32'd0, 1'b0,1'b0,32'd0,32'd0, 1'b0,32'd0,1'b0,1'b0,32'd0,1'b1,1'b0, 1'b0,32'd0);
        step(1'b0,1'b0,32'd0,32'd0, 1'b0,1'b0,32'd0,32'd0, 1'b0,32'd0,1'b0,1'b0,32'd0,1'b0,1'b0, 1'b0,32'd0);

        @(negedge clk); #1;
        chk(step_id, "cq_empty", 32'(cq.size()), 32'd0);
        chk(step_id, "rq_empty", 32'(rq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
